// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared matrix geometry and fetch FSM state encoding.
package matrix_pkg;

   localparam int MAT_DIM = 4;
   localparam int ELEM_W  = 16;
   localparam int ROW_W   = MAT_DIM * ELEM_W;
   localparam int MAT_W   = MAT_DIM * ROW_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERR   = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - per-row acknowledge timeout counter.
// Only built when MATRIX_FETCH_TIMEOUT_EN is defined.
`ifdef MATRIX_FETCH_TIMEOUT_EN
module fetch_watchdog #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;

   // Fires on the edge where the count would reach TIMEOUT_CYCLES.
   assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && !expired) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule
`endif

// File: rtl/matrix_fetch.sv
// rtl/matrix_fetch.sv - fetches a 4x4 matrix of 16-bit elements row by row and pulses matrix_valid.
// Optional ack timeout with fetch_err output: MATRIX_FETCH_TIMEOUT_EN.
module matrix_fetch
   import matrix_pkg::*;
#(
   parameter int ADDR_W = 12
`ifdef MATRIX_FETCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 15
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [ROW_W-1:0]  mem_data,
   input  logic              mem_ack,
   output logic [MAT_W-1:0]  matrix,
   output logic              matrix_valid,
`ifdef MATRIX_FETCH_TIMEOUT_EN
   output logic              fetch_err,
`endif
   output logic              busy
);

   fetch_state_e state_q;
   logic [1:0]   row_q;

`ifdef MATRIX_FETCH_TIMEOUT_EN
   logic wd_expired;

   // Counter restarts for every row: held clear in IDLE and on each ack.
   fetch_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  ((state_q == ST_IDLE) || mem_ack),
      .enable (state_q == ST_FETCH),
      .expired(wd_expired)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         mem_rd       <= 1'b0;
         mem_addr     <= '0;
         matrix       <= '0;
         matrix_valid <= 1'b0;
         busy         <= 1'b0;
`ifdef MATRIX_FETCH_TIMEOUT_EN
         fetch_err    <= 1'b0;
`endif
      end else begin
         matrix_valid <= 1'b0;
`ifdef MATRIX_FETCH_TIMEOUT_EN
         fetch_err    <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mem_addr <= base_addr;
                  row_q    <= '0;
                  mem_rd   <= 1'b1;
                  busy     <= 1'b1;
                  state_q  <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (mem_ack) begin
                  matrix[row_q*ROW_W +: ROW_W] <= mem_data;
                  if (row_q == 2'(MAT_DIM - 1)) begin
                     mem_rd       <= 1'b0;
                     matrix_valid <= 1'b1;
                     state_q      <= ST_DONE;
                  end else begin
                     row_q    <= row_q + 2'd1;
                     mem_addr <= mem_addr + ADDR_W'(1);
                  end
`ifdef MATRIX_FETCH_TIMEOUT_EN
               end else if (wd_expired) begin
                  mem_rd    <= 1'b0;
                  fetch_err <= 1'b1;
                  state_q   <= ST_ERR;
`endif
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               state_q <= ST_IDLE;
            end
`ifdef MATRIX_FETCH_TIMEOUT_EN
            ST_ERR: begin
               busy    <= 1'b0;
               state_q <= ST_IDLE;
            end
`endif
            default: begin
               mem_rd  <= 1'b0;
               busy    <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
